// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared op encoding and reset constant for the bitwise logic unit
package logic_pkg;

    typedef enum logic [2:0] {
        OpAnd  = 3'd0,
        OpOr   = 3'd1,
        OpXor  = 3'd2,
        OpNand = 3'd3,
        OpNor  = 3'd4,
        OpXnor = 3'd5,
        OpAndn = 3'd6,
        OpPass = 3'd7
    } opType;

    // Widest legal operand; narrower instances take the low bits.
    localparam int MaxWidth = 64;
    localparam logic [MaxWidth-1:0] ResetAccDefault = '0;

endpackage

// File: rtl/bitwise_op.sv
// rtl/bitwise_op.sv - combinational per-bit logic operation Y = Op(X, B)
module bitwise_op
    import logic_pkg::*;
#(
    parameter int BitWidth = 8
) (
    input  logic [BitWidth-1:0] X,
    input  logic [BitWidth-1:0] B,
    input  logic [2:0]          Op,
    output logic [BitWidth-1:0] Y
);

    always_comb begin
        Y = '0;
        case (opType'(Op))
            OpAnd:  Y = X & B;
            OpOr:   Y = X | B;
            OpXor:  Y = X ^ B;
            OpNand: Y = ~(X & B);
            OpNor:  Y = ~(X | B);
            OpXnor: Y = ~(X ^ B);
            OpAndn: Y = X & ~B;
            OpPass: Y = X;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - handshaked bitwise logic unit with chainable accumulator
module bitwise_logic_unit
    import logic_pkg::*;
#(
    parameter int                  BitWidth = 8,
    parameter logic [BitWidth-1:0] ResetAcc = BitWidth'(ResetAccDefault)
) (
    input  logic                Clk,
    input  logic                Rst_N,
    input  logic [BitWidth-1:0] A,
    input  logic [BitWidth-1:0] B,
    input  logic [2:0]          Op,
    input  logic                Chain,
    input  logic                Clear,
    input  logic                In_Valid,
    output logic                In_Ready,
    output logic [BitWidth-1:0] C,
    output logic                Out_Valid,
    input  logic                Out_Ready
);

    logic [BitWidth-1:0] acc;
    logic [BitWidth-1:0] opX;
    logic [BitWidth-1:0] opY;
    logic                accept;

    // Single output slot: accept whenever it is empty or being drained this cycle.
    assign In_Ready = !Out_Valid || Out_Ready;
    assign accept   = In_Valid && In_Ready;
    assign opX      = Chain ? acc : A;

    bitwise_op #(
        .BitWidth(BitWidth)
    ) opUnit (
        .X (opX),
        .B (B),
        .Op(Op),
        .Y (opY)
    );

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            Out_Valid <= 1'b0;
            C         <= '0;
            acc       <= ResetAcc;
        end else begin
            if (accept) begin
                C         <= opY;
                Out_Valid <= 1'b1;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
            // Clear outranks the beat; the beat itself already used the old value.
            if (Clear) begin
                acc <= ResetAcc;
            end else if (accept) begin
                acc <= opY;
            end
        end
    end

endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 The block SHALL have parameter BitWidth, default 8: operand and result width in bits, legal range 1 to 64.
REQ-002 The block SHALL have parameter ResetAcc, default all-zeros: accumulator value after reset and after Clear.
REQ-003 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Rst_N  input  1  reset, asynchronous and active-low.
REQ-005 A  input  BitWidth  first operand.
REQ-006 B  input  BitWidth  second operand.
REQ-007 Op  input  3  operation select, encoded per REQ-013.
REQ-008 Chain  input  1  when 1, the accumulator replaces A as the first operand.
REQ-009 Clear  input  1  loads ResetAcc into the accumulator.
REQ-010 In_Valid / In_Ready  input / output  1 / 1  input handshake; A, B, Op and Chain are sampled when both are 1.
REQ-011 C  output  BitWidth  registered result.
REQ-012 Out_Valid / Out_Ready  output / input  1 / 1  output handshake; C is consumed when both are 1.

Function
REQ-013 Op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (X & ~B), 7 PASS (X).
REQ-014 The first operand X SHALL be A when Chain=0 and the accumulator when Chain=1; the second operand SHALL always be B.
REQ-015 An input beat SHALL be accepted when In_Valid and In_Ready are both 1.
REQ-016 In_Ready SHALL equal (!Out_Valid || Out_Ready), which gives a single output register with full throughput and no combinational path from In_Valid to Out_Valid.
REQ-017 On an accepted beat, C SHALL load Op(X, B) and Out_Valid SHALL be 1 on the next cycle, giving a latency of exactly 1 cycle.
REQ-018 On an accepted beat, the accumulator SHALL load the same Op(X, B) value.
REQ-019 When no beat is accepted, the accumulator SHALL hold its value.
REQ-020 Out_Valid SHALL fall after a handshake on the output in which no new beat is accepted.
REQ-021 While Out_Valid=1 and Out_Ready=0, C and Out_Valid SHALL hold stable.
REQ-022 When Clear=1, the accumulator SHALL load ResetAcc, regardless of the handshake.
REQ-023 If Clear=1 in the same cycle as an accepted beat, the beat SHALL still produce C normally; Clear SHALL win for the accumulator.
REQ-024 If Clear=1 in the same cycle as an accepted Chain=1 beat, the beat SHALL use the pre-clear accumulator value.
REQ-025 Op values SHALL be applied independently per bit, with no carry or cross-bit dependence.
REQ-026 Inputs SHALL be ignored when In_Valid=0.

Reset
REQ-027 Asserting Rst_N=0 SHALL immediately force Out_Valid=0, C=0 and accumulator=ResetAcc, including mid-transfer; any pending result is discarded.
REQ-028 In_Ready SHALL read 1 during reset.
REQ-029 The first accept after reset SHALL occur no earlier than the first Clk edge with Rst_N=1.

Structure
REQ-030 The Op encoding SHALL be an enumerated type, and the ResetAcc default a constant, both in the shared package logic_pkg.
REQ-031 The per-bit operation SHALL be a combinational sub-module bitwise_op (inputs X, B, Op; output Y, width BitWidth).
REQ-032 The handshake and the accumulator SHALL live in bitwise_logic_unit.

Verification
REQ-033 Reset, then BitWidth=8, A=8'hF0, B=8'h3C, Chain=0, Op stepped 0..7 with Out_Ready=1 -> C = 30, FC, CC, CF, 03, 33, C0, F0 on consecutive cycles, Out_Valid continuously 1.
REQ-034 Chain sequence: Clear, then OR B=01, OR B=02, OR B=04, AND B=06 -> C = 01, 03, 07, 06.
REQ-035 Backpressure: Out_Ready=0 for 5 cycles with In_Valid=1 -> exactly one beat accepted, In_Ready=0 and C stable for those 5 cycles, next beat accepted on the cycle Out_Ready returns to 1.
REQ-036 Simultaneous events: accumulator=0F, Clear=1 with an accepted Chain=1 XOR beat, B=FF -> C=F0, accumulator=00 afterwards.
REQ-037 Rst_N pulsed low asynchronously mid-cycle while Out_Valid=1 and Out_Ready=0 -> Out_Valid=0 and C=00 immediately, no stale result delivered after release.
REQ-038 Random handshake test at BitWidth=1 and BitWidth=64 against a reference model -> every accepted beat is delivered exactly once, in order.
